// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ requesters,
// with per-message locking and a per-byte completion timeout.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   i_req/i_last/i_byte   per-requester request, end-of-message flag, data byte
//   o_grant               one-hot current owner (zero when unowned)
//   o_ack                 one-cycle pulse to the owner once its byte is sent
//   o_tx_dv/o_tx_byte     launch pulse and byte towards the UART transmitter
//   i_tx_active/i_tx_done transmitter busy level and completion pulse
//   o_busy                arbiter not idle or a message lock is held
//   o_timeout             one-cycle pulse when a byte is aborted
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ-1:0]   i_last,
  input  logic [8*N_REQ-1:0] i_byte,
  output logic [N_REQ-1:0]   o_grant,
  output logic [N_REQ-1:0]   o_ack,
  output logic               o_tx_dv,
  output logic [7:0]         o_tx_byte,
  input  logic               i_tx_active,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t             state_q, state_d;
  logic               lock_q, lock_d;
  logic               last_q, last_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_d, ack_d;
  logic               tx_dv_d, busy_d, timeout_d;
  logic [7:0]         tx_byte_d;
  logic               rr_found, launch;
  logic [IDX_W-1:0]   rr_win, launch_idx;

  // (a + b) mod N_REQ on requester indices
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a, input int unsigned b);
    int unsigned s;
    s = (32'(a) + b) % N_REQ;
    return IDX_W'(s);
  endfunction

  // Round-robin search starting at ptr
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!rr_found && i_req[wrap_add(ptr_q, i)]) begin
        rr_found = 1'b1;
        rr_win   = wrap_add(ptr_q, i);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    last_d     = last_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    grant_d    = o_grant;
    ack_d      = '0;
    tx_dv_d    = 1'b0;
    tx_byte_d  = o_tx_byte;
    timeout_d  = 1'b0;
    launch     = 1'b0;
    launch_idx = owner_q;

    case (state_q)
      ST_IDLE: begin
        if (lock_q) begin
          if (!i_req[owner_q]) begin
            // owner walked away mid-message
            lock_d  = 1'b0;
            grant_d = '0;
            ptr_d   = wrap_add(owner_q, 1);
          end else if (!i_tx_active) begin
            launch     = 1'b1;
            launch_idx = owner_q;
          end
        end else if (!i_tx_active && rr_found) begin
          launch     = 1'b1;
          launch_idx = rr_win;
        end
        if (launch) begin
          owner_d             = launch_idx;
          grant_d             = '0;
          grant_d[launch_idx] = 1'b1;
          tx_byte_d           = i_byte[32'(launch_idx)*8 +: 8];
          last_d              = i_last[launch_idx];
          tx_dv_d             = 1'b1;
          lock_d              = 1'b1;
          cnt_d               = '0;
          state_d             = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // completion takes priority over a coincident terminal count
        if (i_tx_done) begin
          state_d        = ST_ACK;
          ack_d[owner_q] = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          lock_d    = 1'b0;
          grant_d   = '0;
          ptr_d     = wrap_add(owner_q, 1);
          state_d   = ST_IDLE;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        if (last_q) begin
          lock_d  = 1'b0;
          grant_d = '0;
          ptr_d   = wrap_add(owner_q, 1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) | lock_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      lock_q    <= 1'b0;
      last_q    <= 1'b0;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      o_grant   <= '0;
      o_ack     <= '0;
      o_tx_dv   <= 1'b0;
      o_tx_byte <= 8'h00;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      last_q    <= last_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      o_grant   <= grant_d;
      o_ack     <= ack_d;
      o_tx_dv   <= tx_dv_d;
      o_tx_byte <= tx_byte_d;
      o_busy    <= busy_d;
      o_timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester message queues and a
// round-robin/lock reference model predict every grant, byte, ack and timeout.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 1000;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   i_req, i_last;
  logic [8*N-1:0] i_byte;
  logic [N-1:0]   o_grant, o_ack;
  logic           o_tx_dv;
  logic [7:0]     o_tx_byte;
  logic           i_tx_active, i_tx_done;
  logic           o_busy, o_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // per-requester pending bytes: {last, byte}
  logic [8:0] q [N][$];
  logic [7:0] launched [$];
  int m_ptr;
  bit m_lock;
  int m_owner;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_last(i_last), .i_byte(i_byte),
    .o_grant(o_grant), .o_ack(o_ack), .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte),
    .i_tx_active(i_tx_active), .i_tx_done(i_tx_done), .o_busy(o_busy),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < N; k++) begin
      if (q[k].size() > 0) begin
        i_req[k]        = 1'b1;
        i_byte[8*k +: 8] = q[k][0][7:0];
        i_last[k]       = q[k][0][8];
      end else begin
        i_req[k]        = 1'b0;
        i_byte[8*k +: 8] = 8'h00;
        i_last[k]       = 1'b0;
      end
    end
  endtask

  function automatic int exp_winner();
    if (m_lock) return (q[m_owner].size() > 0) ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (q[k].size() > 0) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_lock = 0; m_owner = 0;
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) q[k].delete();
    drive_reqs();
    i_tx_done = 1'b0; i_tx_active = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    model_reset();
    launched.delete();
  endtask

  // Called at the sample where a launch is expected; completes the byte after delay cycles
  task automatic serve(input int delay);
    int w;
    logic [N-1:0] eg, eg_after;
    bit bad, last;
    w = exp_winner();
    n_checks++;
    if (w < 0) begin
      n_fail++;
      $display("FAIL launch_unexpected: tx_dv=%0b grant=%b, required no pending launch", o_tx_dv, o_grant);
      return;
    end
    eg = '0; eg[w] = 1'b1;
    if (o_tx_dv !== 1'b1 || o_grant !== eg || o_tx_byte !== q[w][0][7:0]) begin
      n_fail++;
      $display("FAIL launch: tx_dv=%0b grant=%b byte=%h, required 1 %b %h", o_tx_dv, o_grant, o_tx_byte, eg, q[w][0][7:0]);
    end
    launched.push_back(o_tx_byte);
    i_tx_active = 1'b1;
    bad = 0;
    for (int c = 1; c < delay; c++) begin
      step();
      if (o_tx_dv !== 1'b0 || o_ack !== '0 || o_timeout !== 1'b0 || o_busy !== 1'b1 || o_grant !== eg) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL in_flight: spurious tx_dv/ack/timeout or wrong busy/grant while waiting, required quiet with grant %b", eg);
    end
    i_tx_done = 1'b1; i_tx_active = 1'b0;
    step();
    i_tx_done = 1'b0;
    n_checks++;
    if (o_ack !== eg || o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL ack: ack=%b timeout=%0b, required %b 0", o_ack, o_timeout, eg);
    end
    last = q[w][0][8];
    void'(q[w].pop_front());
    if (last) begin m_lock = 0; m_ptr = (w + 1) % N; end
    else begin m_lock = 1; m_owner = w; end
    drive_reqs();
    step();
    eg_after = last ? '0 : eg;
    n_checks++;
    if (o_ack !== '0 || o_grant !== eg_after || o_timeout !== 1'b0 || o_busy !== !last) begin
      n_fail++;
      $display("FAIL release: ack=%b grant=%b timeout=%0b busy=%0b, required 0 %b 0 %0b", o_ack, o_grant, o_timeout, o_busy, eg_after, !last);
    end
  endtask

  // Serve all queued traffic; each launch must follow the previous ack by one idle cycle
  task automatic drain(input int lo, input int hi);
    bit pend;
    for (int n = 0; n < 64; n++) begin
      step();
      pend = (exp_winner() >= 0);
      n_checks++;
      if (o_tx_dv !== pend) begin
        n_fail++;
        $display("FAIL launch_latency: tx_dv=%0b, required %0b", o_tx_dv, pend);
      end
      if (!pend) begin
        n_checks++;
        if (o_busy !== 1'b0 || o_grant !== '0) begin
          n_fail++;
          $display("FAIL idle: busy=%0b grant=%b, required 0 0", o_busy, o_grant);
        end
        break;
      end
      serve($urandom_range(hi, lo));
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o_grant !== '0 || o_ack !== '0 || o_tx_dv !== 1'b0 || o_tx_byte !== 8'h00 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: grant=%b ack=%b dv=%0b byte=%h busy=%0b to=%0b, required all zero", o_grant, o_ack, o_tx_dv, o_tx_byte, o_busy, o_timeout);
    end
  endtask

  task automatic test_single();
    do_reset();
    q[0].push_back({1'b1, 8'hA5});
    drive_reqs();
    step();
    serve(870);
    q[0].push_back({1'b1, 8'h01});
    q[1].push_back({1'b1, 8'h02});
    drive_reqs();
    drain(2, 10);
    n_checks++;
    if (launched.size() != 3 || launched[0] !== 8'hA5 || launched[1] !== 8'h02 || launched[2] !== 8'h01) begin
      n_fail++;
      $display("FAIL single_ptr: %0d bytes launched, required order A5 02 01", launched.size());
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_f [5];
    bit ok;
    exp_f = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h50};
    do_reset();
    for (int k = 0; k < N; k++) q[k].push_back({1'b1, 8'(8'h10 + k)});
    q[0].push_back({1'b1, 8'h50});
    drive_reqs();
    drain(2, 20);
    ok = (launched.size() == 5);
    for (int i = 0; i < 5 && ok; i++) if (launched[i] !== exp_f[i]) ok = 0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL fairness_order: %0d bytes launched, required 10 11 12 13 50", launched.size());
    end
  endtask

  task automatic test_lock();
    logic [7:0] exp_l [4];
    bit ok;
    exp_l = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    q[0].push_back({1'b0, 8'h11});
    q[0].push_back({1'b0, 8'h22});
    q[0].push_back({1'b1, 8'h33});
    q[1].push_back({1'b1, 8'h44});
    drive_reqs();
    drain(2, 20);
    ok = (launched.size() == 4);
    for (int i = 0; i < 4 && ok; i++) if (launched[i] !== exp_l[i]) ok = 0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL lock_order: %0d bytes launched, required 11 22 33 44", launched.size());
    end
  endtask

  task automatic test_timeout_and_reset();
    int hit;
    bit saw_ack;
    int w;
    logic [N-1:0] eg;
    do_reset();
    q[2].push_back({1'b1, 8'hC3});
    drive_reqs();
    step();
    n_checks++;
    if (o_tx_dv !== 1'b1 || o_grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL timeout_grant: dv=%0b grant=%b, required 1 0100", o_tx_dv, o_grant);
    end
    hit = -1; saw_ack = 0;
    for (int c = 1; c <= 1100; c++) begin
      step();
      if (o_ack !== '0) saw_ack = 1;
      if (o_timeout === 1'b1) begin hit = c; break; end
    end
    n_checks++;
    if (hit != TO) begin
      n_fail++;
      $display("FAIL timeout_latency: pulse %0d cycles after tx_dv, required %0d", hit, TO);
    end
    n_checks++;
    if (saw_ack || o_ack !== '0 || o_grant !== '0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_release: ack_seen=%0b grant=%b busy=%0b, required 0 0 0", saw_ack, o_grant, o_busy);
    end
    m_lock = 0; m_ptr = 3;
    q[3].push_back({1'b1, 8'h3D});
    q[0].push_back({1'b1, 8'h0D});
    drive_reqs();
    step();
    w = exp_winner();
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    n_checks++;
    if (o_tx_dv !== 1'b1 || o_grant !== eg || o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_next_winner: dv=%0b grant=%b to=%0b, required 1 %b 0", o_tx_dv, o_grant, o_timeout, eg);
    end
    // reset while requester 3 is in flight
    for (int k = 0; k < N; k++) q[k].delete();
    q[0].push_back({1'b1, 8'h5A});
    drive_reqs();
    rst = 1'b1;
    step();
    n_checks++;
    if (o_grant !== '0 || o_ack !== '0 || o_tx_dv !== 1'b0 || o_tx_byte !== 8'h00 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_reset: grant=%b ack=%b dv=%0b byte=%h busy=%0b to=%0b, required all zero", o_grant, o_ack, o_tx_dv, o_tx_byte, o_busy, o_timeout);
    end
    rst = 1'b0;
    model_reset();
    step();
    serve(40);
    drain(1, 10);
  endtask

  task automatic test_tx_active();
    bit bad;
    i_tx_active = 1'b1;
    q[1].push_back({1'b1, 8'h77});
    drive_reqs();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_tx_dv !== 1'b0 || o_grant !== '0) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL tx_active_block: launch or grant seen while transmitter busy, required none");
    end
    i_tx_active = 1'b0;
    drain(1, 10);
  endtask

  task automatic test_done_at_terminal();
    q[2].push_back({1'b1, 8'hE7});
    drive_reqs();
    step();
    serve(TO);
    drain(1, 10);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(1, 0) == 1) begin
          int len;
          len = $urandom_range(3, 1);
          for (int j = 0; j < len; j++) q[k].push_back({(j == len - 1), 8'($urandom)});
        end
      end
      drive_reqs();
      drain(1, 30);
    end
  endtask

  initial begin
    rst = 1'b1; i_req = '0; i_last = '0; i_byte = '0;
    i_tx_active = 1'b0; i_tx_done = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_timeout_and_reset();
    test_tx_active();
    test_done_at_terminal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one UART transmitter, range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 1000: maximum cycles from the tx_dv launch to tx_done before the byte is aborted; must exceed 10*CLK_PER_BIT (870).
REQ-003 clk  in  1  system clock; all logic on posedge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 i_req  in  N_REQ  per-requester byte request; held high until o_ack.
REQ-006 i_last  in  N_REQ  per-requester flag: the presented byte ends the message.
REQ-007 i_byte  in  8*N_REQ  requester k data on bits [8k+7:8k].
REQ-008 o_grant  out  N_REQ  one-hot current owner; zero when no owner.
REQ-009 o_ack  out  N_REQ  one-cycle pulse to the owner when its byte has been transmitted.
REQ-010 o_tx_dv  out  1  one-cycle launch pulse to the UART transmitter.
REQ-011 o_tx_byte  out  8  byte to the transmitter; valid while o_tx_dv=1 and held until the next launch.
REQ-012 i_tx_active  in  1  transmitter busy.
REQ-013 i_tx_done  in  1  transmitter one-cycle completion pulse.
REQ-014 o_busy  out  1  high when state is not IDLE or a message lock is held.
REQ-015 o_timeout  out  1  one-cycle pulse when a byte is aborted by timeout.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT, ACK. All outputs SHALL be registered.
REQ-017 IDLE, unlocked, i_tx_active=0, any i_req high: the arbiter SHALL choose winner w by round-robin search starting at ptr (ptr, ptr+1, ... mod N_REQ).
REQ-018 On that grant edge, the arbiter SHALL set o_grant=1<<w, o_tx_byte=i_byte[w], latch i_last[w], pulse o_tx_dv, set lock, clear the timeout counter, and enter WAIT. Latency from req sampled to o_tx_dv is 1 cycle.
REQ-019 IDLE, locked: only the owner's i_req SHALL be considered, and it SHALL launch per REQ-018 without re-arbitration.
REQ-020 IDLE, locked, owner i_req low: the arbiter SHALL release the lock, clear o_grant, and set ptr=(owner+1) mod N_REQ (message abandoned).
REQ-021 IDLE with i_tx_active=1: the arbiter SHALL make no grant and no launch.
REQ-022 WAIT: the counter SHALL increment each cycle. On i_tx_done=1 the FSM SHALL go to ACK.
REQ-023 WAIT, counter == TIMEOUT_CYC-1 with i_tx_done=0: the arbiter SHALL pulse o_timeout, issue no o_ack, release the lock, clear o_grant, advance ptr past the owner, and return to IDLE.
REQ-024 In WAIT, i_tx_done and timeout on the same cycle: done SHALL win and no o_timeout SHALL be issued.
REQ-025 ACK (one cycle): o_ack[owner]=1.
REQ-026 ACK with latched last=1: the arbiter SHALL release the lock, clear o_grant, and set ptr=(owner+1) mod N_REQ. With last=0 it SHALL keep the lock and o_grant. Next state is IDLE in both cases.
REQ-027 i_tx_done in IDLE or ACK SHALL be ignored.
REQ-028 Requester contract: i_req, i_byte and i_last are stable from assertion until o_ack. The next byte or deassertion is presented on the edge that ends o_ack.
REQ-029 The counter width SHALL be $clog2(TIMEOUT_CYC+1). No wrap is possible.
REQ-030 o_busy SHALL be (state!=IDLE) | lock.

Reset
REQ-031 rst=1 at any edge SHALL force: state=IDLE, lock=0, ptr=0, counter=0, o_grant=0, o_ack=0, o_tx_dv=0, o_tx_byte=8'h00, o_timeout=0, o_busy=0.
REQ-032 Reset mid-message SHALL discard the in-flight byte silently, with no o_ack and no o_timeout.

Verification
REQ-033 Single byte: req[0]=1, byte0=8'hA5, last0=1 -> next cycle o_grant=4'b0001, o_tx_dv=1, o_tx_byte=A5; i_tx_done after 870 cycles -> o_ack[0] pulse 1 cycle later; ptr=1.
REQ-034 Fairness: req=4'b1111 continuously, all last=1 -> tx_dv order is requester 0,1,2,3,0; each transmission is acked once.
REQ-035 Lock: req0 sends 3 bytes 11,22,33 (last on 33) while req1=1 -> bytes 11,22,33 go out consecutively before the requester 1 byte.
REQ-036 Timeout: TIMEOUT_CYC=1000, grant req2, no i_tx_done -> o_timeout pulse 1000 cycles after tx_dv, no ack[2], o_grant=0, next winner is requester 3.
REQ-037 Mid-flight reset: rst asserted in WAIT -> all outputs at reset values next cycle; a pending req0 relaunches 1 cycle after rst deasserts.
REQ-038 Edge cases: i_tx_done coincident with the terminal count -> ack with no timeout; i_tx_active=1 in IDLE with req pending -> no tx_dv until it drops.
